// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a byte stream (16-bit word count,
// big-endian payload words, XOR checksum), writes each word, and gates CPU reset.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  // Largest legal word count; one bit wider than the header so 2**16 fits.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [15:0]         rem_q, rem_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          chk_q, chk_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic                we_d;
  logic [31:0]         addr_d, wdata_d;
  logic                acc;
  logic [15:0]         hdr;

  assign acc = byte_valid & byte_ready;
  assign hdr = {cnt_hi_q, byte_in};

  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    rem_d    = rem_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    chk_d    = chk_q;
    widx_d   = widx_q;
    we_d     = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_HI;
          chk_d   = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          rem_d   = '0;
        end
      end
      S_HDR_HI: begin
        if (acc) begin
          cnt_hi_d = byte_in;
          state_d  = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (acc) begin
          rem_d = hdr;
          if ({1'b0, hdr} > CAP)  state_d = S_ERR;
          else if (hdr == 16'd0)  state_d = S_CHECK;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc) begin
          chk_d   = chk_q ^ byte_in;
          bcnt_d  = bcnt_q + 2'd1;
          shift_d = {shift_q[15:0], byte_in};
          // Word complete: the write is registered and lands next cycle.
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {shift_q, byte_in};
            addr_d  = 32'(widx_q);
            widx_d  = widx_q + 1'b1;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (acc) state_d = (byte_in == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_hi_q   <= '0;
      rem_q      <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      chk_q      <= '0;
      widx_q     <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      rem_q      <= rem_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      chk_q      <= chk_d;
      widx_q     <= widx_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      byte_ready <= state_d inside {S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK};
      busy       <= state_d inside {S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK};
      done       <= (state_d == S_DONE);
      error      <= (state_d == S_ERR);
      cpu_hold   <= (state_d != S_DONE);
    end
  end

endmodule
